// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter : two-master (CPU / video-DMA) arbiter in front of the SDRAM
//                 controller's single valid/ready request port.
// Revision      : 1.0
// ============================================================================
module sdram_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_din,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_dout,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_din,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_dout,
  output logic              m1_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   r_last_grant;
  logic   r_ready_q;
  logic   w_cmp;
  logic   w_take;
  logic   w_sel;
  logic   w_done;

  // Only a rising edge of mem_ready counts, so the controller's level-high
  // ready during its init phase never completes a transaction.
  assign w_cmp  = mem_ready & ~r_ready_q;
  assign w_done = (r_state == S_BUSY) && w_cmp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_sel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          w_take      = 1'b1;
          w_state_nxt = S_BUSY;
          if (m0_valid && m1_valid) begin
            w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
          end else begin
            w_sel = m1_valid;
          end
        end
      end
      S_BUSY: begin
        if (w_cmp) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_q    <= 1'b1;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_wmask    <= '0;
      m0_dout      <= '0;
      m0_ready     <= 1'b0;
      m1_dout      <= '0;
      m1_ready     <= 1'b0;
    end else begin
      r_ready_q <= mem_ready;
      // Ready pulses are raised only on completion, so DONE clears them.
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      if (w_take) begin
        r_grant   <= w_sel;
        mem_valid <= 1'b1;
        mem_addr  <= w_sel ? m1_addr  : m0_addr;
        mem_din   <= w_sel ? m1_din   : m0_din;
        mem_wmask <= w_sel ? m1_wmask : m0_wmask;
      end
      if (w_done) begin
        mem_valid    <= 1'b0;
        r_last_grant <= r_grant;
        if (r_grant) begin
          m1_dout  <= mem_dout;
          m1_ready <= 1'b1;
        end else begin
          m0_dout  <= mem_dout;
          m0_ready <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// Scoreboard bench for sdram_arbiter: instance 0 is round-robin, instance 1
// is fixed-priority; a behavioural controller answers each request.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m0_valid, m1_valid, m0_ready, m1_ready, mem_valid, mem_ready;
  logic [24:0] m0_addr [2];
  logic [24:0] m1_addr [2];
  logic [24:0] mem_addr [2];
  logic [31:0] m0_din [2];
  logic [31:0] m1_din [2];
  logic [31:0] m0_dout [2];
  logic [31:0] m1_dout [2];
  logic [31:0] mem_din [2];
  logic [31:0] mem_dout [2];
  logic [3:0]  m0_wmask [2];
  logic [3:0]  m1_wmask [2];
  logic [3:0]  mem_wmask [2];
  logic [1:0]  auto_en;
  logic [1:0]  man_rdy;
  logic [31:0] man_dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    int          m;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  sdram_arbiter #(.FIXED_PRIO(0), .ADDR_W(25)) u_rr (
    .clk(clk), .reset(rst),
    .m0_valid(m0_valid[0]), .m0_addr(m0_addr[0]), .m0_din(m0_din[0]), .m0_wmask(m0_wmask[0]),
    .m0_dout(m0_dout[0]), .m0_ready(m0_ready[0]),
    .m1_valid(m1_valid[0]), .m1_addr(m1_addr[0]), .m1_din(m1_din[0]), .m1_wmask(m1_wmask[0]),
    .m1_dout(m1_dout[0]), .m1_ready(m1_ready[0]),
    .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_wmask(mem_wmask[0]),
    .mem_dout(mem_dout[0]), .mem_ready(mem_ready[0])
  );

  sdram_arbiter #(.FIXED_PRIO(1), .ADDR_W(25)) u_fp (
    .clk(clk), .reset(rst),
    .m0_valid(m0_valid[1]), .m0_addr(m0_addr[1]), .m0_din(m0_din[1]), .m0_wmask(m0_wmask[1]),
    .m0_dout(m0_dout[1]), .m0_ready(m0_ready[1]),
    .m1_valid(m1_valid[1]), .m1_addr(m1_addr[1]), .m1_din(m1_din[1]), .m1_wmask(m1_wmask[1]),
    .m1_dout(m1_dout[1]), .m1_ready(m1_ready[1]),
    .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_wmask(mem_wmask[1]),
    .mem_dout(mem_dout[1]), .mem_ready(mem_ready[1])
  );

  // Controller model: one-cycle ready pulse 10 cycles after mem_valid rises.
  // Read data: DEADBEEF at 0x0001234, otherwise {7'h55, addr}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    logic [3:0]  cnt;
    logic        rdy;
    logic [31:0] rd;
    always @(posedge clk) begin
      if (rst || !auto_en[gi] || !mem_valid[gi]) begin
        cnt <= 4'd0;
        rdy <= 1'b0;
        if (rst) rd <= 32'h0;
      end else if (rdy) begin
        cnt <= 4'd0;
        rdy <= 1'b0;
      end else if (cnt == 4'd9) begin
        rdy <= 1'b1;
        rd  <= (mem_addr[gi] == 25'h0001234) ? 32'hDEADBEEF : {7'h55, mem_addr[gi]};
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
    assign mem_ready[gi] = auto_en[gi] ? rdy : man_rdy[gi];
    assign mem_dout[gi]  = auto_en[gi] ? rd  : man_dout;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m0_ready[i] || m1_ready[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready inst=%0d: got m0_ready=%b m1_ready=%b, required no ready",
                   i, m0_ready[i], m1_ready[i]);
        end else begin
          e = exp_q.pop_front();
          if (e.inst != i || (e.m == 1) != m1_ready[i] || m0_ready[i] == m1_ready[i] ||
              (m1_ready[i] ? m1_dout[i] : m0_dout[i]) !== e.d) begin
            errors++;
            $display("FAIL response inst=%0d: got m0_ready=%b m1_ready=%b m0_dout=%h m1_dout=%h, required inst=%0d master=%0d dout=%h",
                     i, m0_ready[i], m1_ready[i], m0_dout[i], m1_dout[i], e.inst, e.m, e.d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int m, input logic [31:0] d);
    exp_t x;
    x.inst = i;
    x.m    = m;
    x.d    = d;
    exp_q.push_back(x);
  endtask

  task automatic drive(input int i, input int m, input logic v, input logic [24:0] a,
                       input logic [31:0] d, input logic [3:0] w);
    if (m == 0) begin
      m0_valid[i] = v; m0_addr[i] = a; m0_din[i] = d; m0_wmask[i] = w;
    end else begin
      m1_valid[i] = v; m1_addr[i] = a; m1_din[i] = d; m1_wmask[i] = w;
    end
  endtask

  task automatic wait_rdy(input int i, input int m, input int bound);
    bit seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      seen = (m == 0) ? m0_ready[i] : m1_ready[i];
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_ready inst=%0d m=%0d: got no ready, required ready within %0d cycles",
               i, m, bound);
    end
  endtask

  // Master keeps valid until ready, drops it in the DONE cycle, re-raises in IDLE.
  task automatic run_master(input int i, input int m, input int n, input logic [24:0] base);
    for (int k = 0; k < n; k++) begin
      drive(i, m, 1'b1, base + 25'(k), 32'h0, 4'h0);
      wait_rdy(i, m, 400);
      drive(i, m, 1'b0, base + 25'(k), 32'h0, 4'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    m0_valid = 2'b00;
    m1_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b0, 25'h0, 32'h0, 4'h0);
      drive(i, 1, 1'b0, 25'h0, 32'h0, 4'h0);
    end
    auto_en  = 2'b10;
    man_rdy  = 2'b11;
    man_dout = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_mem_valid", 32'(mem_valid[i]), 32'h0);
      check("rst_mem_addr",  32'(mem_addr[i]),  32'h0);
      check("rst_mem_din",   mem_din[i],        32'h0);
      check("rst_mem_wmask", 32'(mem_wmask[i]), 32'h0);
      check("rst_m0_dout",   m0_dout[i],        32'h0);
      check("rst_m1_dout",   m1_dout[i],        32'h0);
      check("rst_readies",   32'({m0_ready[i], m1_ready[i]}), 32'h0);
    end

    // Controller ready held high after reset must not complete anything.
    drive(0, 0, 1'b1, 25'h0000ABC, 32'h0, 4'h0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("init_mem_valid", 32'(mem_valid[0]), 32'h1);
    check("init_mem_addr",  32'(mem_addr[0]),  32'h0000ABC);
    push_exp(0, 0, 32'h600DF00D);
    man_dout = 32'h600DF00D;
    @(posedge clk); #1 man_rdy[0] = 1'b0;
    @(posedge clk); #1 man_rdy[0] = 1'b1;
    @(posedge clk); #1 man_rdy[0] = 1'b0;
    wait_rdy(0, 0, 20);
    m0_valid[0] = 1'b0;
    @(negedge clk);
    check("init_single_pulse", 32'(m0_ready[0]), 32'h0);
    auto_en[0] = 1'b1;

    // Single read by master 0.
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 25'h0001234, 32'h0, 4'h0);
    push_exp(0, 0, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_valid_latency0", 32'(mem_valid[0]), 32'h0);
    @(negedge clk);
    check("rd_valid_latency1", 32'(mem_valid[0]), 32'h1);
    check("rd_mem_addr",       32'(mem_addr[0]),  32'h0001234);
    check("rd_mem_wmask",      32'(mem_wmask[0]), 32'h0);
    wait_rdy(0, 0, 40);
    m0_valid[0] = 1'b0;
    check("rd_m0_dout",       m0_dout[0], 32'hDEADBEEF);
    check("rd_m1_dout_clean", m1_dout[0], 32'h0);

    // Write by master 1; its inputs change mid-transaction.
    @(posedge clk); #1;
    drive(0, 1, 1'b1, 25'h1FFFFFF, 32'hA5A55A5A, 4'b0011);
    push_exp(0, 1, 32'hABFFFFFF);
    repeat (3) @(negedge clk);
    m1_din[0]   = 32'h12345678;
    m1_wmask[0] = 4'hF;
    m1_addr[0]  = 25'h0;
    repeat (3) @(negedge clk);
    check("wr_mem_valid", 32'(mem_valid[0]), 32'h1);
    check("wr_mem_din",   mem_din[0],        32'hA5A55A5A);
    check("wr_mem_wmask", 32'(mem_wmask[0]), 32'h3);
    check("wr_mem_addr",  32'(mem_addr[0]),  32'h1FFFFFF);
    wait_rdy(0, 1, 40);
    m1_valid[0] = 1'b0;
    check("wr_m0_dout_kept", m0_dout[0], 32'hDEADBEEF);

    // Round-robin: both masters busy, grants alternate starting with 0.
    @(posedge clk); #1;
    push_exp(0, 0, 32'hAA000100);
    push_exp(0, 1, 32'hAA000200);
    push_exp(0, 0, 32'hAA000101);
    push_exp(0, 1, 32'hAA000201);
    fork
      run_master(0, 0, 2, 25'h100);
      run_master(0, 1, 2, 25'h200);
    join

    // Fixed priority: master 0 wins every tie, master 1 served last.
    push_exp(1, 0, 32'hAA000100);
    push_exp(1, 0, 32'hAA000101);
    push_exp(1, 0, 32'hAA000102);
    push_exp(1, 0, 32'hAA000103);
    push_exp(1, 1, 32'hAA000200);
    fork
      run_master(1, 0, 4, 25'h100);
      run_master(1, 1, 1, 25'h200);
    join

    // Reset three cycles into BUSY aborts silently.
    auto_en[0] = 1'b0;
    man_rdy[0] = 1'b0;
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 25'h0000055, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_valid", 32'(mem_valid[0]), 32'h0);
    check("abort_mem_addr",  32'(mem_addr[0]),  32'h0);
    check("abort_m0_ready",  32'(m0_ready[0]),  32'h0);
    m0_valid[0] = 1'b0;
    man_rdy[0]  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 man_rdy[0] = 1'b0;
    @(posedge clk); #1 man_rdy[0] = 1'b1;
    @(posedge clk); #1 man_rdy[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_idle_valid", 32'(mem_valid[0]), 32'h0);
    end

    // Arbiter is back in IDLE and serves a fresh request.
    auto_en[0] = 1'b1;
    @(posedge clk); #1;
    drive(0, 1, 1'b1, 25'h0000300, 32'h0, 4'h0);
    push_exp(0, 1, 32'hAA000300);
    wait_rdy(0, 1, 40);
    m1_valid[0] = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
